inertial_interface: RTL and testbench



---
 rtl/inertial_interface.sv | 132 +++++++++++++
 tb/tb_inertial_interface.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inertial_interface.sv
// Inertial sensor SPI front end: configures the sensor after a power-up settle
// interval, then reads pitch rate and Z acceleration on each data-ready interrupt.
module inertial_interface #(
  parameter int unsigned INIT_WAIT_BITS = 16,
  parameter logic [7:0]  PTCH_L_ADDR    = 8'hA2,
  parameter logic [7:0]  PTCH_H_ADDR    = 8'hA3,
  parameter logic [7:0]  AZ_L_ADDR      = 8'hAC,
  parameter logic [7:0]  AZ_H_ADDR      = 8'hAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  localparam logic [3:0] INIT_WAIT = 4'd0;
  localparam logic [3:0] CFG1      = 4'd1;
  localparam logic [3:0] CFG2      = 4'd2;
  localparam logic [3:0] CFG3      = 4'd3;
  localparam logic [3:0] CFG4      = 4'd4;
  localparam logic [3:0] WAIT_INT  = 4'd5;
  localparam logic [3:0] RD_PL     = 4'd6;
  localparam logic [3:0] RD_PH     = 4'd7;
  localparam logic [3:0] RD_AZL    = 4'd8;
  localparam logic [3:0] RD_AZH    = 4'd9;

  logic [3:0]                r_state;
  logic [INIT_WAIT_BITS-1:0] r_settle;
  logic                      r_int_ff1;
  logic                      r_int_ff2;
  logic [7:0]                r_ptch_lo;
  logic [7:0]                r_ptch_hi;
  logic [7:0]                r_az_lo;
  logic                      r_wrt;
  logic                      r_vld;
  logic [15:0]               r_cmd;
  logic [15:0]               r_ptch_rt;
  logic [15:0]               r_az;

  logic [3:0]  w_nxt_state;
  logic        w_issue;
  logic [15:0] w_cmd;
  logic        w_load;
  logic        w_unused_rd_hi;

  assign wrt            = r_wrt;
  assign cmd            = r_cmd;
  assign vld            = r_vld;
  assign ptch_rt        = r_ptch_rt;
  assign AZ             = r_az;
  assign w_unused_rd_hi = ^rd_data[15:8];

  always_comb begin
    w_nxt_state = r_state;
    w_issue     = 1'b0;
    w_cmd       = r_cmd;
    w_load      = 1'b0;
    case (r_state)
      INIT_WAIT: if (&r_settle) begin
        w_issue = 1'b1; w_cmd = 16'h0D02; w_nxt_state = CFG1;
      end
      CFG1: if (done) begin
        w_issue = 1'b1; w_cmd = 16'h1053; w_nxt_state = CFG2;
      end
      CFG2: if (done) begin
        w_issue = 1'b1; w_cmd = 16'h1150; w_nxt_state = CFG3;
      end
      CFG3: if (done) begin
        w_issue = 1'b1; w_cmd = 16'h1460; w_nxt_state = CFG4;
      end
      CFG4: if (done) w_nxt_state = WAIT_INT;
      WAIT_INT: if (r_int_ff2) begin
        w_issue = 1'b1; w_cmd = {PTCH_L_ADDR, 8'h00}; w_nxt_state = RD_PL;
      end
      RD_PL: if (done) begin
        w_issue = 1'b1; w_cmd = {PTCH_H_ADDR, 8'h00}; w_nxt_state = RD_PH;
      end
      RD_PH: if (done) begin
        w_issue = 1'b1; w_cmd = {AZ_L_ADDR, 8'h00}; w_nxt_state = RD_AZL;
      end
      RD_AZL: if (done) begin
        w_issue = 1'b1; w_cmd = {AZ_H_ADDR, 8'h00}; w_nxt_state = RD_AZH;
      end
      RD_AZH: if (done) begin
        w_load = 1'b1; w_nxt_state = WAIT_INT;
      end
      default: w_nxt_state = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= INIT_WAIT;
      r_settle  <= '0;
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
      r_ptch_lo <= '0;
      r_ptch_hi <= '0;
      r_az_lo   <= '0;
      r_wrt     <= 1'b0;
      r_vld     <= 1'b0;
      r_cmd     <= '0;
      r_ptch_rt <= '0;
      r_az      <= '0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
      r_state   <= w_nxt_state;
      r_wrt     <= w_issue;
      r_vld     <= w_load;
      r_cmd     <= w_cmd;
      // Settle counter stops at all-ones; it is only consumed once per reset
      if (r_state == INIT_WAIT && !(&r_settle))
        r_settle <= r_settle + {{(INIT_WAIT_BITS-1){1'b0}}, 1'b1};
      if (done && r_state == RD_PL)  r_ptch_lo <= rd_data[7:0];
      if (done && r_state == RD_PH)  r_ptch_hi <= rd_data[7:0];
      if (done && r_state == RD_AZL) r_az_lo   <= rd_data[7:0];
      // Both words update together so consumers never see a half-read sample
      if (w_load) begin
        r_ptch_rt <= {r_ptch_hi, r_ptch_lo};
        r_az      <= {rd_data[7:0], r_az_lo};
      end
    end
  end

endmodule

// File: tb/tb_inertial_interface.sv
// Bench for inertial_interface: SPI master / sensor model with randomized register
// contents, checking configuration order, read chain, output timing and reset.
module tb_inertial_interface;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT;
  logic        done = 1'b0;
  logic [15:0] rd_data = '0;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int int_events = 0, int_served = 0, spur_req = 0, spur_served = 0;
  int wrt_cnt = 0, vld_cnt = 0, vld_cyc = 0, azh_done_cyc = 0;
  int cfg_done_cyc = 0, cfg_done_cnt = 0, viol = 0;
  logic [7:0]  sens [4];
  logic [15:0] log_cmd [$];
  int          log_cyc [$];
  logic [15:0] vld_p = '0, vld_a = '0, prev_p = '0, prev_a = '0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [15:0] cur_cmd = '0;

  // Sensor raises INT per event and clears it when the first read is served
  assign INT = (int_events != int_served);

  inertial_interface #(.INIT_WAIT_BITS(4)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ)
  );

  always #5 clk = ~clk;

  // SPI master + sensor model, and output monitor, all sampled on negedge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (vld) begin vld_cnt++; vld_cyc = cyc; vld_p = ptch_rt; vld_a = AZ; end
      if (!rst && !vld && (ptch_rt !== prev_p || AZ !== prev_a)) viol++;
      prev_p = ptch_rt; prev_a = AZ;
      done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            logic [7:0] b;
            pend = 1'b0;
            done = 1'b1;
            case (cur_cmd[15:8])
              8'hA2:   begin b = sens[0]; int_served++; end
              8'hA3:   b = sens[1];
              8'hAC:   b = sens[2];
              8'hAD:   begin b = sens[3]; azh_done_cyc = cyc; end
              default: b = 8'($urandom);
            endcase
            rd_data = {8'($urandom), b};
            if (cur_cmd == 16'h1460) begin cfg_done_cyc = cyc; cfg_done_cnt++; end
          end
        end else if (spur_req != spur_served) begin
          done = 1'b1;
          rd_data = 16'($urandom);
          spur_served++;
        end
        if (wrt) begin
          wrt_cnt++;
          log_cmd.push_back(cmd);
          log_cyc.push_back(cyc);
          cur_cmd = cmd;
          pend = 1'b1;
          cnt = 40;
        end
      end
    end
  end

  task automatic release_and_count(output int n);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!wrt && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic wait_vld(input int base, input int limit);
    int t = 0;
    while (vld_cnt == base && t < limit) begin @(negedge clk); t++; end
    n_chk++;
    if (vld_cnt == base) $display("FAIL vld_timeout: no vld within %0d cycles", limit);
    else n_pass++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_chk++; if (wrt !== 1'b0) $display("FAIL reset_wrt: got %b expected 0", wrt); else n_pass++;
    n_chk++; if (cmd !== 16'h0000) $display("FAIL reset_cmd: got %h expected 0000", cmd); else n_pass++;
    n_chk++; if (vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", vld); else n_pass++;
    n_chk++; if (ptch_rt !== 16'h0000) $display("FAIL reset_ptch: got %h expected 0000", ptch_rt); else n_pass++;
    n_chk++; if (AZ !== 16'h0000) $display("FAIL reset_az: got %h expected 0000", AZ); else n_pass++;
  endtask

  task automatic test_powerup;
    int n, t, st, bw, bc;
    logic [15:0] exp [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    bit ok;
    st = log_cmd.size(); bw = wrt_cnt; bc = cfg_done_cnt;
    int_events = int_events;
    release_and_count(n);
    n_chk++; if (n != 16) $display("FAIL settle_time: got %0d clks expected 16", n); else n_pass++;
    n_chk++; if (cmd !== 16'h0D02) $display("FAIL first_cmd: got %h expected 0D02", cmd); else n_pass++;
    t = 0;
    while (cfg_done_cnt == bc && t < 400) begin @(negedge clk); t++; end
    n_chk++; if (cfg_done_cnt == bc) $display("FAIL cfg_timeout: config not done in 400 cycles"); else n_pass++;
    repeat (3) @(negedge clk);
    ok = (log_cmd.size() == st + 4);
    for (int i = 0; i < 4 && ok; i++) if (log_cmd[st+i] !== exp[i]) ok = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL cfg_seq: got %0d cmds, last %h, expected 0D02 1053 1150 1460",
                      log_cmd.size() - st, log_cmd.size() > 0 ? log_cmd[$] : 16'h0);
    else n_pass++;
    n_chk++; if (wrt_cnt - bw != 4) $display("FAIL cfg_wrt_count: got %0d expected 4", wrt_cnt - bw); else n_pass++;
  endtask

  task automatic test_read;
    int st, base;
    logic [15:0] exp [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    bit ok;
    sens = '{8'h34, 8'h12, 8'h78, 8'hF6};
    st = log_cmd.size(); base = vld_cnt;
    int_events++;
    wait_vld(base, 600);
    n_chk++; if (vld_p !== 16'h1234) $display("FAIL read_ptch: got %h expected 1234", vld_p); else n_pass++;
    n_chk++; if (vld_a !== 16'hF678) $display("FAIL read_az: got %h expected F678", vld_a); else n_pass++;
    n_chk++; if (!($signed(AZ) < 0)) $display("FAIL read_az_sign: got %0d expected negative", $signed(AZ)); else n_pass++;
    ok = (log_cmd.size() == st + 4);
    for (int i = 0; i < 4 && ok; i++) if (log_cmd[st+i] !== exp[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL read_cmds: got %0d cmds expected A200 A300 AC00 AD00", log_cmd.size() - st); else n_pass++;
    n_chk++; if (vld_cyc - azh_done_cyc != 1) $display("FAIL read_latency: got %0d expected 1", vld_cyc - azh_done_cyc); else n_pass++;
    repeat (60) @(negedge clk);
    n_chk++; if (vld_cnt != base + 1) $display("FAIL read_single_vld: got %0d pulses expected 1", vld_cnt - base); else n_pass++;
  endtask

  task automatic test_int_early;
    int n, st, base, d;
    logic [15:0] exp [5] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460, 16'hA200};
    bit ok;
    for (int i = 0; i < 4; i++) sens[i] = 8'($urandom);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    st = log_cmd.size(); base = vld_cnt;
    int_events++;
    release_and_count(n);
    wait_vld(base, 900);
    ok = (log_cmd.size() >= st + 5);
    for (int i = 0; i < 5 && ok; i++) if (log_cmd[st+i] !== exp[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL early_int_order: got %0d cmds expected cfg then A200", log_cmd.size() - st); else n_pass++;
    d = ok ? log_cyc[st+4] - cfg_done_cyc : -1;
    n_chk++; if (d < 1 || d > 3) $display("FAIL early_int_start: got %0d clks expected 1..3", d); else n_pass++;
    n_chk++; if (vld_p !== {sens[1], sens[0]}) $display("FAIL early_ptch: got %h expected %h", vld_p, {sens[1], sens[0]}); else n_pass++;
    n_chk++; if (vld_a !== {sens[3], sens[2]}) $display("FAIL early_az: got %h expected %h", vld_a, {sens[3], sens[2]}); else n_pass++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_spurious_done;
    int bw, bv;
    logic [15:0] p, a;
    bw = wrt_cnt; bv = vld_cnt; p = ptch_rt; a = AZ;
    spur_req++;
    repeat (20) @(negedge clk);
    n_chk++; if (wrt_cnt != bw) $display("FAIL spur_wrt: got %0d wrt pulses expected 0", wrt_cnt - bw); else n_pass++;
    n_chk++; if (vld_cnt != bv) $display("FAIL spur_vld: got %0d vld pulses expected 0", vld_cnt - bv); else n_pass++;
    n_chk++; if (ptch_rt !== p) $display("FAIL spur_ptch: got %h expected %h", ptch_rt, p); else n_pass++;
    n_chk++; if (AZ !== a) $display("FAIL spur_az: got %h expected %h", AZ, a); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n, t, st, base;
    logic [15:0] exp [5] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460, 16'hA200};
    bit ok;
    st = log_cmd.size();
    int_events++;
    t = 0;
    while (log_cmd.size() < st + 2 && t < 300) begin @(negedge clk); t++; end
    n_chk++; if (log_cmd.size() < st + 2) $display("FAIL mid_timeout: RD_PH read not issued"); else n_pass++;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (wrt !== 1'b0) $display("FAIL mid_rst_wrt: got %b expected 0", wrt); else n_pass++;
    n_chk++; if (vld !== 1'b0) $display("FAIL mid_rst_vld: got %b expected 0", vld); else n_pass++;
    n_chk++; if (cmd !== 16'h0000) $display("FAIL mid_rst_cmd: got %h expected 0000", cmd); else n_pass++;
    n_chk++; if (ptch_rt !== 16'h0000) $display("FAIL mid_rst_ptch: got %h expected 0000", ptch_rt); else n_pass++;
    n_chk++; if (AZ !== 16'h0000) $display("FAIL mid_rst_az: got %h expected 0000", AZ); else n_pass++;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) sens[i] = 8'($urandom);
    st = log_cmd.size(); base = vld_cnt;
    int_events++;
    release_and_count(n);
    n_chk++; if (n != 16) $display("FAIL mid_settle: got %0d clks expected 16", n); else n_pass++;
    wait_vld(base, 900);
    ok = (log_cmd.size() >= st + 5);
    for (int i = 0; i < 5 && ok; i++) if (log_cmd[st+i] !== exp[i]) ok = 1'b0;
    n_chk++; if (!ok) $display("FAIL mid_reconfig: got %0d cmds expected cfg then A200", log_cmd.size() - st); else n_pass++;
    n_chk++; if (vld_p !== {sens[1], sens[0]}) $display("FAIL mid_ptch: got %h expected %h", vld_p, {sens[1], sens[0]}); else n_pass++;
    n_chk++; if (vld_a !== {sens[3], sens[2]}) $display("FAIL mid_az: got %h expected %h", vld_a, {sens[3], sens[2]}); else n_pass++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int base;
    logic [15:0] ep, ea;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) sens[i] = 8'($urandom);
      ep = (16'(sens[1]) << 8) | 16'(sens[0]);
      ea = (16'(sens[3]) << 8) | 16'(sens[2]);
      base = vld_cnt;
      int_events++;
      wait_vld(base, 600);
      n_chk++; if (vld_p !== ep) $display("FAIL b2b_ptch%0d: got %h expected %h", k, vld_p, ep); else n_pass++;
      n_chk++; if (vld_a !== ea) $display("FAIL b2b_az%0d: got %h expected %h", k, vld_a, ea); else n_pass++;
      repeat (30) @(negedge clk);
      n_chk++; if (ptch_rt !== ep || AZ !== ea)
        $display("FAIL b2b_hold%0d: got %h/%h expected %h/%h", k, ptch_rt, AZ, ep, ea);
      else n_pass++;
    end
    n_chk++; if (viol != 0) $display("FAIL output_stability: got %0d changes without vld expected 0", viol); else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) sens[i] = 8'h00;
    test_reset();
    test_powerup();
    test_read();
    test_int_early();
    test_spurious_done();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
